decade_phase_decoder: RTL and testbench
=======================================

DECADE_PHASE_DECODER -- requirements
Module: decade_phase_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the input synchronizer depth (legal range 1..3).
REQ-002 clk  input  1  sole clock SHALL be clk; all state SHALL update on its rising edge.
REQ-003 mr  input  1  master reset SHALL be asynchronous and active-high.
REQ-004 q  input  10  decoded one-hot outputs of a decade counter; q[n] high means count n.
REQ-005 _co  input  1  counter carry-out, active-low; high for counts 0..4, low for counts 5..9.
REQ-006 en  input  1  high SHALL enable tracking; low SHALL freeze all state except the synchronizer.
REQ-007 bcd  output  4  encoded current count, 0..9.
REQ-008 valid  output  1  high while state is TRACK.
REQ-009 wrap  output  1  one-cycle pulse on each accepted 9->0 transition.
REQ-010 wraps  output  8  count of accepted wraps, saturating at 255.
REQ-011 err  output  1  sticky fault flag.
REQ-012 err_code  output  2  first-fault cause: 0 none, 1 not one-hot, 2 illegal step, 3 _co mismatch.

Function
REQ-013 q and _co SHALL pass through a SYNC_STAGES-deep flop chain before any use; the synchronized pair is "sample" below.
REQ-014 A sample SHALL be one-hot iff exactly one of its 10 bits is high.
REQ-015 FSM states SHALL be SYNC, TRACK, FAULT.
REQ-016 SYNC: ignore samples until sample q == 10'b0000000001 with _co == 1; then enter TRACK with bcd = 0.
REQ-017 SYNC: malformed samples SHALL NOT raise err.
REQ-018 TRACK, legal sample: q equal to the previous accepted q (hold) or its 1-bit rotate-left (advance); rotate of q[9] is q[0].
REQ-019 TRACK, advance: bcd SHALL update to the new index on the cycle after the sample.
REQ-020 TRACK, advance 9->0: wrap SHALL pulse for exactly one cycle, and wraps SHALL increment unless already 255.
REQ-021 TRACK, sample not one-hot -> FAULT, err_code = 1.
REQ-022 TRACK, one-hot sample that is neither hold nor advance -> FAULT, err_code = 2.
REQ-023 TRACK, _co != (index <= 4) -> FAULT, err_code = 3.
REQ-024 Fault priority SHALL be 1 over 2 over 3 when several apply in the same cycle.
REQ-025 On entry to FAULT, err SHALL set; err and err_code SHALL hold until mr, including after return to TRACK.
REQ-026 FAULT: valid = 0, bcd holds its last good value, and wrap = 0.
REQ-027 FAULT -> SYNC on the first sample with q == 10'b0000000001 and _co == 1.
REQ-028 en = 0: the FSM, bcd, wraps and err SHALL hold, and wrap SHALL be 0.
REQ-029 en = 0: the previous-q register SHALL follow the sample, so stepping resumes relative to the latest sample when en returns high.
REQ-030 Latency SHALL be SYNC_STAGES + 1 clk cycles from a q change at the pins to the bcd or wrap change.

Reset
REQ-031 While mr is high, all outputs SHALL be forced and held as follows: bcd = 0, valid = 0, wrap = 0, wraps = 0, err = 0, err_code = 0.
REQ-032 While mr is high, the state SHALL be SYNC and the synchronizer flops SHALL be 0.
REQ-033 mr SHALL take effect immediately, without a clock, including mid-transition in any state.
REQ-034 mr SHALL dominate en and every input event.
REQ-035 After mr falls, the first sample SHALL be taken on the next rising clk.

Verification
REQ-036 Reset then q = 1, _co = 1 held 5 cycles -> valid = 1 by cycle 3, bcd = 0, err = 0.
REQ-037 Advance q one bit per 4 cycles with correct _co through 0..9..0 -> bcd steps 0..9 then 0, one wrap pulse, wraps = 1.
REQ-038 From TRACK at count 3, apply q = 10'b0000100000 -> FAULT, err = 1, err_code = 2, valid = 0, bcd = 3.
REQ-039 From TRACK at count 5, apply _co = 1 -> err_code = 3; then q = 10'b0000000011 -> err_code stays 3; then q = 1, _co = 1 -> valid = 1, err = 1.
REQ-040 Drive 300 full decade cycles -> wraps = 255, no error; pulse mr mid-cycle without clk -> all outputs 0 immediately.
REQ-041 In TRACK, set en = 0, advance q twice, then set en = 1 -> bcd held while en = 0, then resumes from the new q with no fault.

Source files
------------

// File: rtl/decade_phase_decoder.sv
// Tracks the one-hot outputs of a decade counter, encodes the count, and counts
// 9->0 wraps. Phase faults are latched until master reset.
module decade_phase_decoder #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       mr,
   input  logic [9:0] q,
   input  logic       _co,
   input  logic       en,
   output logic [3:0] bcd,
   output logic       valid,
   output logic       wrap,
   output logic [7:0] wraps,
   output logic       err,
   output logic [1:0] err_code
);

   typedef enum logic [1:0] {StSync, StTrack, StFault} state_e;

   logic [10:0] sync_q [SYNC_STAGES];
   logic [10:0] sync_d [SYNC_STAGES];

   state_e      state_q, state_d;
   logic [9:0]  prev_q_q, prev_q_d;
   logic [3:0]  bcd_q, bcd_d;
   logic        wrap_q, wrap_d;
   logic [7:0]  wraps_q, wraps_d;
   logic        err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;

   logic [9:0]  s_q;
   logic        s_co;
   logic [3:0]  ones;
   logic [3:0]  idx;
   logic        onehot;
   logic        is_hold;
   logic        is_adv;
   logic        is_start;
   logic [1:0]  fault;

   assign s_q  = sync_q[SYNC_STAGES-1][9:0];
   assign s_co = sync_q[SYNC_STAGES-1][10];

   always_comb begin
      sync_d[0] = {_co, q};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_comb begin
      ones = 4'd0;
      idx  = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (s_q[i]) begin
            ones = ones + 4'd1;
            idx  = 4'(i);
         end
      end
   end

   assign onehot   = (ones == 4'd1);
   assign is_hold  = (s_q == prev_q_q);
   assign is_adv   = (s_q == {prev_q_q[8:0], prev_q_q[9]});
   assign is_start = (s_q == 10'b0000000001) && s_co;

   always_comb begin
      state_d    = state_q;
      prev_q_d   = prev_q_q;
      bcd_d      = bcd_q;
      wrap_d     = 1'b0;
      wraps_d    = wraps_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      fault      = 2'd0;

      if (!en) begin
         // Keep the step reference current so tracking resumes from the latest sample.
         prev_q_d = s_q;
      end else begin
         case (state_q)
            StSync: begin
               if (is_start) begin
                  state_d  = StTrack;
                  bcd_d    = 4'd0;
                  prev_q_d = s_q;
               end
            end
            StTrack: begin
               if (!onehot) begin
                  fault = 2'd1;
               end else if (!is_hold && !is_adv) begin
                  fault = 2'd2;
               end else if (s_co != (idx <= 4'd4)) begin
                  fault = 2'd3;
               end

               if (fault != 2'd0) begin
                  state_d = StFault;
                  err_d   = 1'b1;
                  if (!err_q) begin
                     err_code_d = fault;
                  end
               end else begin
                  prev_q_d = s_q;
                  bcd_d    = idx;
                  if (is_adv && prev_q_q[9]) begin
                     wrap_d = 1'b1;
                     if (wraps_q != 8'hff) begin
                        wraps_d = wraps_q + 8'd1;
                     end
                  end
               end
            end
            StFault: begin
               if (is_start) begin
                  state_d = StSync;
               end
            end
            default: state_d = StSync;
         endcase
      end
   end

   always_ff @(posedge clk or posedge mr) begin
      if (mr) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         state_q    <= StSync;
         prev_q_q   <= '0;
         bcd_q      <= '0;
         wrap_q     <= 1'b0;
         wraps_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         state_q    <= state_d;
         prev_q_q   <= prev_q_d;
         bcd_q      <= bcd_d;
         wrap_q     <= wrap_d;
         wraps_q    <= wraps_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign bcd      = bcd_q;
   assign valid    = (state_q == StTrack);
   assign wrap     = wrap_q;
   assign wraps    = wraps_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule

// File: tb/tb_decade_phase_decoder.sv
// Directed self-checking bench for decade_phase_decoder with the default
// two-stage synchronizer (three-edge latency from pins to outputs).
module tb_decade_phase_decoder;

   logic       clk;
   logic       mr;
   logic [9:0] q;
   logic       co;
   logic       en;
   logic [3:0] bcd;
   logic       valid;
   logic       wrap;
   logic [7:0] wraps;
   logic       err;
   logic [1:0] err_code;

   int n_cmp;
   int n_err;
   int wrap_seen;

   decade_phase_decoder #(
      .SYNC_STAGES(2)
   ) u_dut (
      .clk      (clk),
      .mr       (mr),
      .q        (q),
      ._co      (co),
      .en       (en),
      .bcd      (bcd),
      .valid    (valid),
      .wrap     (wrap),
      .wraps    (wraps),
      .err      (err),
      .err_code (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int n);
      q    = '0;
      q[n] = 1'b1;
      co   = (n <= 4);
   endtask

   // Drive count n, let it settle, and count wrap-pulse cycles on the way.
   task automatic step_to(input int n);
      drive(n);
      repeat (4) begin
         tick();
         if (wrap) wrap_seen++;
      end
   endtask

   task automatic do_reset();
      mr = 1'b1;
      en = 1'b1;
      drive(0);
      tick();
      tick();
      mr = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      wrap_seen = 0;
      mr = 1'b1;
      en = 1'b1;
      q  = '0;
      co = 1'b0;
      tick();
      tick();
      check_eq("rst_bcd", 32'(bcd), 0);
      check_eq("rst_valid", 32'(valid), 0);
      check_eq("rst_wrap", 32'(wrap), 0);
      check_eq("rst_wraps", 32'(wraps), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_code", 32'(err_code), 0);

      // Lock-on: valid appears on the third edge after reset release.
      drive(0);
      mr = 1'b0;
      tick();
      tick();
      check_eq("lock_early_valid", 32'(valid), 0);
      tick();
      check_eq("lock_valid", 32'(valid), 1);
      check_eq("lock_bcd", 32'(bcd), 0);
      check_eq("lock_err", 32'(err), 0);
      tick();
      tick();

      // Latency of one advance, then a full decade with one wrap.
      drive(1);
      tick();
      tick();
      check_eq("lat_bcd_hold", 32'(bcd), 0);
      tick();
      check_eq("lat_bcd_step", 32'(bcd), 1);
      tick();
      wrap_seen = 0;
      for (int n = 2; n <= 10; n++) begin
         step_to(n % 10);
         check_eq($sformatf("decade_bcd_%0d", n % 10), 32'(bcd), 32'(n % 10));
      end
      check_eq("decade_wrap_cycles", 32'(wrap_seen), 1);
      check_eq("decade_wraps", 32'(wraps), 1);
      check_eq("decade_err", 32'(err), 0);

      // Illegal step from count 3.
      do_reset();
      for (int n = 1; n <= 3; n++) step_to(n);
      step_to(5);
      check_eq("step_valid", 32'(valid), 0);
      check_eq("step_err", 32'(err), 1);
      check_eq("step_code", 32'(err_code), 2);
      check_eq("step_bcd", 32'(bcd), 3);

      // Not one-hot takes priority.
      do_reset();
      q  = 10'b0000000011;
      co = 1'b0;
      repeat (4) tick();
      check_eq("onehot_code", 32'(err_code), 1);

      // _co mismatch at count 5, sticky code, recovery to TRACK with err kept.
      do_reset();
      for (int n = 1; n <= 5; n++) step_to(n);
      check_eq("co_pre_bcd", 32'(bcd), 5);
      co = 1'b1;
      repeat (4) tick();
      check_eq("co_code", 32'(err_code), 3);
      check_eq("co_valid", 32'(valid), 0);
      check_eq("co_bcd", 32'(bcd), 5);
      q  = 10'b0000000011;
      co = 1'b1;
      repeat (4) tick();
      check_eq("co_sticky_code", 32'(err_code), 3);
      drive(0);
      repeat (6) tick();
      check_eq("recover_valid", 32'(valid), 1);
      check_eq("recover_err", 32'(err), 1);
      check_eq("recover_code", 32'(err_code), 3);
      check_eq("recover_bcd", 32'(bcd), 0);

      // Freeze with en low while the counter moves on.
      do_reset();
      for (int n = 1; n <= 3; n++) step_to(n);
      en = 1'b0;
      step_to(4);
      check_eq("freeze_bcd_a", 32'(bcd), 3);
      step_to(5);
      check_eq("freeze_bcd_b", 32'(bcd), 3);
      check_eq("freeze_valid", 32'(valid), 1);
      en = 1'b1;
      repeat (4) tick();
      check_eq("resume_bcd", 32'(bcd), 5);
      check_eq("resume_err", 32'(err), 0);
      step_to(6);
      check_eq("resume_step_bcd", 32'(bcd), 6);
      check_eq("resume_step_err", 32'(err), 0);

      // Saturation over 300 decades, one count per clock.
      do_reset();
      for (int d = 0; d < 300; d++) begin
         for (int n = 1; n <= 10; n++) begin
            drive(n % 10);
            tick();
         end
      end
      repeat (4) tick();
      check_eq("sat_wraps", 32'(wraps), 255);
      check_eq("sat_err", 32'(err), 0);
      for (int n = 1; n <= 7; n++) begin
         drive(n);
         tick();
      end
      repeat (4) tick();
      check_eq("sat_bcd", 32'(bcd), 7);

      // Asynchronous reset between clock edges.
      #3;
      mr = 1'b1;
      #1;
      check_eq("amr_bcd", 32'(bcd), 0);
      check_eq("amr_valid", 32'(valid), 0);
      check_eq("amr_wrap", 32'(wrap), 0);
      check_eq("amr_wraps", 32'(wraps), 0);
      check_eq("amr_err", 32'(err), 0);
      check_eq("amr_code", 32'(err_code), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
